pudding_cfg_chain: RTL and testbench
====================================

// Module: pudding_cfg_chain
// PURPOSE
//  Parametrised serial configuration chain with a shadow (committed) state register and beat-count checking.
//  Shifts LANES bits per beat into a CHAIN_LEN-bit daisychain and commits atomically into state_q only after
//  exactly CHAIN_LEN/LANES beats. Supports readback of state_q into the chain for serial shift-out.
//  Sits between the top-level pad wrapper (ui_in/uo_out) and any block needing wide static configuration.
// PARAMETERS
//  CHAIN_LEN  256  chain and state width in bits; must be a multiple of LANES
//  LANES      1    bits shifted per beat (1..8)
//  OUT_W      8    width of dout/state_top taps (<= CHAIN_LEN)
//  BEATS      CHAIN_LEN/LANES (localparam); CNT_W = $clog2(BEATS+2)
// PORTS
//  clk        in   1          clock
//  rst_n      in   1          reset, synchronous, active-low
//  din        in   LANES      serial data; din[LANES-1] enters chain first (becomes higher bit)
//  shift      in   1          shift one beat when high
//  commit     in   1          request chain -> state_q copy
//  readback   in   1          request state_q -> chain copy
//  crc_in     in   8          expected CRC-8 of shifted stream (used only with PUDDING_CHAIN_CRC_EN)
//  dout       out  OUT_W      chain[CHAIN_LEN-1 -: OUT_W]
//  state_top  out  OUT_W      state_q[CHAIN_LEN-1 -: OUT_W]
//  state_q    out  CHAIN_LEN  committed configuration
//  beat_cnt   out  CNT_W      beats shifted since last commit/readback/reset, saturates at BEATS+1
//  len_ok     out  1          beat_cnt == BEATS (combinational from regs)
//  ovf        out  1          sticky: beat_cnt exceeded BEATS
//  done       out  1          one-cycle pulse, commit accepted
//  err        out  1          one-cycle pulse, commit rejected or illegal request
// BEHAVIOUR
//  Reset (next clk edge with rst_n=0, overrides everything incl. mid-shift): chain, state_q, beat_cnt, ovf,
//   done, err, CRC = 0. All outputs 0 during/after reset.
//  Priority per cycle: (commit & readback) > readback > commit > shift. Lower priorities ignored that cycle.
//  commit & readback together: err=1 for one cycle; chain, state_q, beat_cnt, ovf unchanged.
//  readback: chain <= state_q; beat_cnt <= 0; ovf <= 0; CRC <= 0. No done/err.
//  commit: if len_ok & !ovf (and CRC match when enabled): state_q <= chain, done=1 next cycle.
//   Otherwise err=1 next cycle, state_q unchanged. Either way beat_cnt <= 0, ovf <= 0, CRC <= 0;
//   chain keeps its contents.
//  shift: chain <= {chain[CHAIN_LEN-LANES-1:0], din}; beat_cnt += 1, saturating at BEATS+1;
//   ovf <= 1 when beat_cnt == BEATS on a shift beat (sticky until commit/readback/reset).
//  Latency: all effects visible on outputs the cycle after the request edge; done/err last exactly 1 cycle.
//  Implicit FSM from beat_cnt/ovf: EMPTY(0) -> FILLING(1..BEATS-1) -> FULL(BEATS) -> OVER(ovf=1);
//   commit/readback return to EMPTY.
//  Shifting after readback shifts state out via dout: OUT_W bits per OUT_W/LANES beats.
// CONFIGURATION
//  PUDDING_CHAIN_CRC_EN defined: 8-bit CRC register (poly 0x07, init 0x00, no reflect, no xorout) updated on
//   every shift beat, lanes processed din[LANES-1] first. Commit additionally requires CRC == crc_in,
//   else err. CRC cleared on commit/readback/reset.
//  Not defined: no CRC logic; crc_in ignored (tie-off only); commit acceptance depends on length only.
// TESTING  (CHAIN_LEN=16, LANES=2, OUT_W=4 unless noted)
//  1 Reset: rst_n=0 one edge with random prior state -> state_q=0, dout=0, beat_cnt=0, ovf=0, done=err=0.
//  2 Shift 8 beats din=2'b10, commit -> pre-commit dout=0xA, len_ok=1; then state_q=0xAAAA, done pulse, beat_cnt=0.
//  3 Shift 7 beats din=2'b11, commit -> err pulse, state_q stays 0xAAAA; shift 9 beats -> ovf=1, commit -> err.
//  4 readback with state_q=0xAAAA -> chain=0xAAAA, dout=0xA; 2 beats din=0 -> dout=0xA; 8 beats -> dout=0.
//  5 commit and readback same cycle after 8 beats -> err pulse only, state_q, chain, beat_cnt=8 unchanged.
//  6 CRC_EN, LANES=1, CHAIN_LEN=256: 256 random beats, crc_in=model CRC -> done; repeat with
//    crc_in = model ^ 0x01 -> err, state_q unchanged.

Source files
------------

// File: rtl/pudding_cfg_chain.sv
// Serial configuration chain with beat counting and atomic commit into a shadow register.
// Optional CRC-8 commit check enabled by defining PUDDING_CHAIN_CRC_EN.
module pudding_cfg_chain #(
    parameter int CHAIN_LEN = 256,
    parameter int LANES     = 1,
    parameter int OUT_W     = 8,
    localparam int BEATS    = CHAIN_LEN / LANES,
    localparam int CNT_W    = $clog2(BEATS + 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LANES-1:0]     din,
    input  logic                 shift,
    input  logic                 commit,
    input  logic                 readback,
    input  logic [7:0]           crc_in,
    output logic [OUT_W-1:0]     dout,
    output logic [OUT_W-1:0]     state_top,
    output logic [CHAIN_LEN-1:0] state_q,
    output logic [CNT_W-1:0]     beat_cnt,
    output logic                 len_ok,
    output logic                 ovf,
    output logic                 done,
    output logic                 err
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BEATS + 1);

    logic [CHAIN_LEN-1:0] chain_q, chain_d, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 do_both, do_rb, do_cm, do_sh;
    logic                 crc_ok;

    assign do_both = commit & readback;
    assign do_rb   = readback & ~commit;
    assign do_cm   = commit & ~readback;
    assign do_sh   = shift & ~commit & ~readback;

`ifdef PUDDING_CHAIN_CRC_EN
    logic [7:0] crc_q, crc_sh;

    // MSB-first CRC-8 (poly 0x07), highest lane enters first
    always_comb begin
        crc_sh = crc_q;
        for (int i = LANES - 1; i >= 0; i--) begin
            crc_sh = {crc_sh[6:0], 1'b0} ^ ((crc_sh[7] ^ din[i]) ? 8'h07 : 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || do_rb || do_cm) begin
            crc_q <= 8'h00;
        end else if (do_sh) begin
            crc_q <= crc_sh;
        end
    end

    assign crc_ok = (crc_q == crc_in);
`else
    logic unused_crc;
    assign unused_crc = ^crc_in;
    assign crc_ok     = 1'b1;
`endif

    assign len_ok = (cnt_q == CNT_FULL);

    always_comb begin
        chain_d = chain_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (do_both) begin
            err_d = 1'b1;
        end else if (do_rb) begin
            chain_d = state_q;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (do_cm) begin
            if (len_ok && !ovf_q && crc_ok) begin
                state_d = chain_q;
                done_d  = 1'b1;
            end else begin
                err_d = 1'b1;
            end
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (do_sh) begin
            chain_d = {chain_q[CHAIN_LEN-LANES-1:0], din};
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_q == CNT_FULL) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= '0;
            state_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            chain_q <= chain_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign dout      = chain_q[CHAIN_LEN-1 -: OUT_W];
    assign state_top = state_q[CHAIN_LEN-1 -: OUT_W];
    assign beat_cnt  = cnt_q;
    assign ovf       = ovf_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pudding_cfg_chain.sv
// Directed bench for pudding_cfg_chain (16-bit chain, 2 lanes, 4-bit taps).
// With PUDDING_CHAIN_CRC_EN a second 256x1 instance exercises the CRC commit check.
module tb_pudding_cfg_chain;

    logic        clk;
    logic        rst_n;
    logic [1:0]  din;
    logic        shift, commit, readback;
    logic [7:0]  crc_m;
    logic [3:0]  dout, state_top;
    logic [15:0] state_q;
    logic [3:0]  beat_cnt;
    logic        len_ok, ovf, done, err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string         tag;
        logic [255:0]  st;
        logic [7:0]    dt;
        logic [15:0]   cnt;
        logic          lok, ov, dn, er;
    } exp_t;

    exp_t sb[$];

    pudding_cfg_chain #(.CHAIN_LEN(16), .LANES(2), .OUT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .shift(shift),
        .commit(commit), .readback(readback), .crc_in(crc_m),
        .dout(dout), .state_top(state_top), .state_q(state_q),
        .beat_cnt(beat_cnt), .len_ok(len_ok), .ovf(ovf),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] crc_upd(logic [7:0] c, logic [7:0] d, int n);
        for (int i = n - 1; i >= 0; i--) begin
            c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_m(string tag, logic [15:0] st, logic [3:0] dt,
                          logic [3:0] cnt, logic lok, logic ov,
                          logic dn, logic er);
        exp_t e;
        e.tag = tag; e.st = 256'(st); e.dt = 8'(dt); e.cnt = 16'(cnt);
        e.lok = lok; e.ov = ov; e.dn = dn; e.er = er;
        sb.push_back(e);
    endtask

    task automatic pop_m();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "/state"}, 256'(state_q), e.st);
        chk({e.tag, "/top"}, 256'(state_top), 256'(e.st[15:12]));
        chk({e.tag, "/dout"}, 256'(dout), 256'(e.dt));
        chk({e.tag, "/cnt"}, 256'(beat_cnt), 256'(e.cnt));
        chk({e.tag, "/len_ok"}, 256'(len_ok), 256'(e.lok));
        chk({e.tag, "/ovf"}, 256'(ovf), 256'(e.ov));
        chk({e.tag, "/done"}, 256'(done), 256'(e.dn));
        chk({e.tag, "/err"}, 256'(err), 256'(e.er));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(logic [1:0] d);
        shift = 1'b1;
        din   = d;
        tick();
        shift = 1'b0;
        crc_m = crc_upd(crc_m, {6'b0, d}, 2);
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        crc_m  = 8'h00;
    endtask

`ifdef PUDDING_CHAIN_CRC_EN
    logic         b_din, b_shift, b_commit, b_readback;
    logic [7:0]   b_crc_in, b_dout, b_top;
    logic [255:0] b_state;
    logic [8:0]   b_cnt;
    logic         b_lok, b_ovf, b_done, b_err;

    pudding_cfg_chain #(.CHAIN_LEN(256), .LANES(1), .OUT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(b_din), .shift(b_shift),
        .commit(b_commit), .readback(b_readback), .crc_in(b_crc_in),
        .dout(b_dout), .state_top(b_top), .state_q(b_state),
        .beat_cnt(b_cnt), .len_ok(b_lok), .ovf(b_ovf),
        .done(b_done), .err(b_err)
    );

    task automatic pop_b();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "/state"}, b_state, e.st);
        chk({e.tag, "/top"}, 256'(b_top), 256'(e.st[255:248]));
        chk({e.tag, "/dout"}, 256'(b_dout), 256'(e.dt));
        chk({e.tag, "/cnt"}, 256'(b_cnt), 256'(e.cnt));
        chk({e.tag, "/done"}, 256'(b_done), 256'(e.dn));
        chk({e.tag, "/err"}, 256'(b_err), 256'(e.er));
    endtask

    task automatic run_big(string tag, logic [7:0] flip,
                           logic [255:0] prev, output logic [255:0] m);
        logic [7:0] c;
        logic       bt;
        exp_t       e;
        c = 8'h00;
        m = '0;
        for (int i = 0; i < 256; i++) begin
            bt      = 1'($urandom_range(0, 1));
            b_din   = bt;
            b_shift = 1'b1;
            tick();
            m = {m[254:0], bt};
            c = crc_upd(c, {7'b0, bt}, 1);
        end
        b_shift  = 1'b0;
        b_crc_in = c ^ flip;
        e.tag = tag;
        e.st  = (flip == 8'h00) ? m : prev;
        e.dt  = m[255:248];
        e.cnt = 16'h0;
        e.lok = 1'b0; e.ov = 1'b0;
        e.dn  = (flip == 8'h00);
        e.er  = (flip != 8'h00);
        sb.push_back(e);
        b_commit = 1'b1;
        tick();
        b_commit = 1'b0;
        pop_b();
    endtask
`endif

    initial begin
        shift = 1'b0; commit = 1'b0; readback = 1'b0; din = 2'b00;
        crc_m = 8'h00;
        rst_n = 1'b0;
`ifdef PUDDING_CHAIN_CRC_EN
        b_din = 1'b0; b_shift = 1'b0; b_commit = 1'b0;
        b_readback = 1'b0; b_crc_in = 8'h00;
`endif
        repeat (2) tick();
        rst_n = 1'b1;

        // random prior state, then reset during a shift
        repeat (8) beat(2'($urandom_range(0, 3)));
        do_commit();
        repeat (3) beat(2'($urandom_range(0, 3)));
        push_m("reset", 16'h0, 4'h0, 4'd0, 0, 0, 0, 0);
        rst_n = 1'b0; shift = 1'b1; din = 2'b11;
        tick();
        rst_n = 1'b1; shift = 1'b0; crc_m = 8'h00;
        pop_m();

        // full-length load and commit
        repeat (8) beat(2'b10);
        push_m("pre_commit", 16'h0, 4'hA, 4'd8, 1, 0, 0, 0);
        pop_m();
        push_m("commit_ok", 16'hAAAA, 4'hA, 4'd0, 0, 0, 1, 0);
        do_commit();
        pop_m();
        push_m("done_pulse", 16'hAAAA, 4'hA, 4'd0, 0, 0, 0, 0);
        tick();
        pop_m();

        // short load, then overflow
        repeat (7) beat(2'b11);
        push_m("short_pre", 16'hAAAA, 4'hB, 4'd7, 0, 0, 0, 0);
        pop_m();
        push_m("short_commit", 16'hAAAA, 4'hB, 4'd0, 0, 0, 0, 1);
        do_commit();
        pop_m();
        push_m("err_pulse", 16'hAAAA, 4'hB, 4'd0, 0, 0, 0, 0);
        tick();
        pop_m();
        repeat (9) beat(2'b11);
        push_m("ovf", 16'hAAAA, 4'hF, 4'd9, 0, 1, 0, 0);
        pop_m();
        beat(2'b11);
        push_m("saturate", 16'hAAAA, 4'hF, 4'd9, 0, 1, 0, 0);
        pop_m();
        push_m("ovf_commit", 16'hAAAA, 4'hF, 4'd0, 0, 0, 0, 1);
        do_commit();
        pop_m();

        // readback wins over a simultaneous shift
        push_m("readback", 16'hAAAA, 4'hA, 4'd0, 0, 0, 0, 0);
        readback = 1'b1; shift = 1'b1; din = 2'b11;
        tick();
        readback = 1'b0; shift = 1'b0; crc_m = 8'h00;
        pop_m();
        repeat (2) beat(2'b00);
        push_m("rb_shift2", 16'hAAAA, 4'hA, 4'd2, 0, 0, 0, 0);
        pop_m();
        repeat (6) beat(2'b00);
        push_m("rb_shift8", 16'hAAAA, 4'h0, 4'd8, 1, 0, 0, 0);
        pop_m();

        // commit + readback together
        push_m("cm_rb", 16'hAAAA, 4'h0, 4'd8, 1, 0, 0, 1);
        commit = 1'b1; readback = 1'b1;
        tick();
        commit = 1'b0; readback = 1'b0;
        pop_m();
        push_m("cm_rb_after", 16'hAAAA, 4'h0, 4'd8, 1, 0, 0, 0);
        tick();
        pop_m();
        push_m("final_commit", 16'h0, 4'h0, 4'd0, 0, 0, 1, 0);
        do_commit();
        pop_m();

`ifdef PUDDING_CHAIN_CRC_EN
        begin
            logic [255:0] m1, m2;
            run_big("crc_good", 8'h00, 256'h0, m1);
            tick();
            run_big("crc_bad", 8'h01, m1, m2);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
